execute_writeback: RTL and testbench

- Back half of the 5-bit-PC pipelined CPU. Consumes the decoded operands and control flags produced by fetch/decode, then runs ALU, branch/jump resolution, data memory and writeback.
- Returns the jump redirect (jump_pc, should_jump) and the register-file write port (write reg, data, enable) to fetch/decode.
- Two internal stages: EX (registered decode outputs) and WB (registered results).

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/alu.sv | 26 ++
 rtl/execute_writeback.sv | 125 ++++++++++++
 tb/tb_execute_writeback.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings and widths for the 5-bit-PC CPU pipeline.
package cpu_pkg;
    localparam int PC_W = 5;
    localparam int XLEN = 32;

    localparam logic [3:0] JT_NONE = 4'd0;
    localparam logic [3:0] JT_BEQ  = 4'd1;
    localparam logic [3:0] JT_BNE  = 4'd2;
    localparam logic [3:0] JT_BLT  = 4'd3;
    localparam logic [3:0] JT_BGE  = 4'd4;
    localparam logic [3:0] JT_JAL  = 4'd5;
    localparam logic [3:0] JT_JALR = 4'd6;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_AND  = 5'd2;
    localparam logic [4:0] ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_SLL  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_SLT  = 5'd8;
    localparam logic [4:0] ALU_SLTU = 5'd9;

    function automatic logic is_link(input logic [3:0] jt);
        return (jt == JT_JAL) || (jt == JT_JALR);
    endfunction
endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; also used as the signed branch comparator.
module alu
    import cpu_pkg::*;
(
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [4:0]      op_i,
    output logic [XLEN-1:0] result_o
);
    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SLL:  result_o = a_i << b_i[4:0];
            ALU_SRL:  result_o = a_i >> b_i[4:0];
            ALU_SRA:  result_o = $unsigned($signed(a_i) >>> b_i[4:0]);
            ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, a_i < b_i};
            default:  result_o = '0;
        endcase
    end
endmodule

// File: rtl/execute_writeback.sv
// EX/WB half of the pipeline: forwarding, ALU, jump resolution, data memory
// and the register-file write port.
module execute_writeback
    import cpu_pkg::*;
#(
    parameter int DMEM_ADDR_W  = 5,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     read_data1,
    input  logic [31:0]     read_data2,
    input  logic [4:0]      rs1_idx,
    input  logic [4:0]      rs2_idx,
    input  logic [31:0]     imm,
    input  logic [4:0]      in_write_reg,
    input  logic            in_reg_wrenable,
    input  logic [3:0]      jump_type,
    input  logic            mem_wrenable,
    input  logic            mem_to_reg,
    input  logic            alu_src,
    input  logic            halt,
    input  logic [4:0]      alu_op,
    input  logic [4:0]      pc,
    output logic [4:0]      jump_pc,
    output logic            should_jump,
    output logic [4:0]      out_write_reg,
    output logic [31:0]     write_data,
    output logic            out_reg_wrenable,
    output logic            done
);
    localparam int SQ_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

    logic            ex_valid_q, ex_we_q, ex_mwe_q, ex_m2r_q, ex_asrc_q, ex_halt_q;
    logic [31:0]     ex_rd1_q, ex_rd2_q, ex_imm_q;
    logic [4:0]      ex_rs1_q, ex_rs2_q, ex_rd_q, ex_op_q, ex_pc_q;
    logic [3:0]      ex_jt_q;
    logic            wb_valid_q, wb_we_q;
    logic [4:0]      wb_rd_q;
    logic [31:0]     wb_data_q;
    logic [SQ_W-1:0] squash_q, squash_d;
    logic            halted_q, halted_d, done_q, cap_valid;

    logic [31:0] dmem [0:(2**DMEM_ADDR_W)-1];

    logic [31:0]     op_a, op_b, alu_b, alu_res, cmp_res, jalr_sum, ex_result;
    logic [PC_W-1:0] br_tgt, pc_inc;
    logic            fwd_a, fwd_b, cond, taken;
    logic [DMEM_ADDR_W-1:0] mem_addr;

    // Only the previous instruction needs bypassing; the regfile covers older ones.
    assign fwd_a = wb_valid_q && wb_we_q && (wb_rd_q == ex_rs1_q) && (ex_rs1_q != 5'd0);
    assign fwd_b = wb_valid_q && wb_we_q && (wb_rd_q == ex_rs2_q) && (ex_rs2_q != 5'd0);
    assign op_a  = fwd_a ? wb_data_q : ex_rd1_q;
    assign op_b  = fwd_b ? wb_data_q : ex_rd2_q;
    assign alu_b = ex_asrc_q ? ex_imm_q : op_b;

    alu u_alu (.a_i(op_a), .b_i(alu_b), .op_i(ex_op_q), .result_o(alu_res));
    alu u_cmp (.a_i(op_a), .b_i(op_b),  .op_i(ALU_SLT), .result_o(cmp_res));

    always_comb begin
        cond = 1'b0;
        case (ex_jt_q)
            JT_BEQ:         cond = (op_a == op_b);
            JT_BNE:         cond = (op_a != op_b);
            JT_BLT:         cond = (cmp_res != '0);
            JT_BGE:         cond = (cmp_res == '0);
            JT_JAL, JT_JALR: cond = 1'b1;
            default:        cond = 1'b0;
        endcase
    end

    assign taken       = ex_valid_q && cond;
    assign br_tgt      = ex_pc_q + ex_imm_q[PC_W-1:0];
    assign jalr_sum    = op_a + ex_imm_q;
    assign should_jump = taken;
    assign jump_pc     = !taken ? '0 : (ex_jt_q == JT_JALR) ? jalr_sum[PC_W-1:0] : br_tgt;
    assign pc_inc      = ex_pc_q + PC_W'(1);
    assign ex_result   = is_link(ex_jt_q) ? {{(XLEN-PC_W){1'b0}}, pc_inc} : alu_res;
    assign mem_addr    = alu_res[DMEM_ADDR_W-1:0];

    // Validity of the capture uses post-edge squash/halt state so the instruction
    // fetched alongside a taken jump or halt is already dropped.
    assign squash_d  = taken ? SQ_W'(FLUSH_CYCLES) :
                       (squash_q != '0) ? squash_q - SQ_W'(1) : squash_q;
    assign halted_d  = halted_q || (ex_valid_q && ex_halt_q);
    assign cap_valid = (squash_d == '0) && !halted_d;

    always_ff @(posedge clk) begin
        if (!rst && ex_valid_q && ex_mwe_q)
            dmem[mem_addr] <= op_b;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q <= 1'b0; ex_we_q <= 1'b0; ex_mwe_q <= 1'b0; ex_m2r_q <= 1'b0;
            ex_asrc_q  <= 1'b0; ex_halt_q <= 1'b0;
            ex_rd1_q   <= '0; ex_rd2_q <= '0; ex_imm_q <= '0;
            ex_rs1_q   <= '0; ex_rs2_q <= '0; ex_rd_q <= '0; ex_op_q <= '0; ex_pc_q <= '0;
            ex_jt_q    <= '0;
            wb_valid_q <= 1'b0; wb_we_q <= 1'b0; wb_rd_q <= '0; wb_data_q <= '0;
            squash_q   <= '0; halted_q <= 1'b0; done_q <= 1'b0;
        end else begin
            ex_valid_q <= cap_valid;
            ex_we_q    <= in_reg_wrenable; ex_mwe_q <= mem_wrenable; ex_m2r_q <= mem_to_reg;
            ex_asrc_q  <= alu_src; ex_halt_q <= halt;
            ex_rd1_q   <= read_data1; ex_rd2_q <= read_data2; ex_imm_q <= imm;
            ex_rs1_q   <= rs1_idx; ex_rs2_q <= rs2_idx; ex_rd_q <= in_write_reg;
            ex_op_q    <= alu_op; ex_pc_q <= pc; ex_jt_q <= jump_type;
            wb_valid_q <= ex_valid_q;
            wb_we_q    <= ex_we_q && (ex_rd_q != 5'd0) && !ex_mwe_q;
            wb_rd_q    <= ex_rd_q;
            wb_data_q  <= ex_m2r_q ? dmem[mem_addr] : ex_result;
            squash_q   <= squash_d;
            halted_q   <= halted_d;
            if (ex_valid_q && ex_halt_q)
                done_q <= 1'b1;
        end
    end

    assign out_write_reg    = wb_rd_q;
    assign write_data       = wb_data_q;
    assign out_reg_wrenable = wb_valid_q && wb_we_q;
    assign done             = done_q;
endmodule

// File: tb/tb_execute_writeback.sv
// Directed bench for execute_writeback with an instruction-level reference model.
module tb_execute_writeback;
    import cpu_pkg::*;

    localparam int FLUSH = 2;

    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] read_data1, read_data2, imm;
    logic [4:0]  rs1_idx, rs2_idx, in_write_reg, alu_op, pc;
    logic        in_reg_wrenable, mem_wrenable, mem_to_reg, alu_src, halt;
    logic [3:0]  jump_type;
    logic [4:0]  jump_pc, out_write_reg;
    logic        should_jump, out_reg_wrenable, done;
    logic [31:0] write_data;

    execute_writeback #(.DMEM_ADDR_W(5), .FLUSH_CYCLES(FLUSH)) dut (
        .clk(clk), .rst(rst), .read_data1(read_data1), .read_data2(read_data2),
        .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .imm(imm), .in_write_reg(in_write_reg),
        .in_reg_wrenable(in_reg_wrenable), .jump_type(jump_type), .mem_wrenable(mem_wrenable),
        .mem_to_reg(mem_to_reg), .alu_src(alu_src), .halt(halt), .alu_op(alu_op), .pc(pc),
        .jump_pc(jump_pc), .should_jump(should_jump), .out_write_reg(out_write_reg),
        .write_data(write_data), .out_reg_wrenable(out_reg_wrenable), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  rs1, rs2, rd, op, pc;
        logic [3:0]  jt;
        logic        we, mwe, m2r, asrc, hlt;
    } ins_t;

    int checks = 0, errors = 0;
    int cyc;
    bit chk_en = 1'b0;

    logic        exp_sj  [0:255];
    logic [4:0]  exp_jpc [0:255];
    logic        exp_we  [0:255];
    logic [4:0]  exp_rd  [0:255];
    logic [31:0] exp_wd  [0:255];

    logic [31:0] mmem [0:31];
    bit          pend_v;
    logic [4:0]  pend_a;
    logic [31:0] pend_d;
    bit          m_prev_we, m_halted;
    logic [4:0]  m_prev_rd;
    logic [31:0] m_prev_val;
    int          m_squash, m_done_from;

    always @(posedge clk or posedge rst)
        if (rst) cyc <= 0; else cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] m_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            5'd0: return a + b;
            5'd1: return a - b;
            5'd2: return a & b;
            5'd3: return a | b;
            5'd4: return a ^ b;
            5'd5: return a << b[4:0];
            5'd6: return a >> b[4:0];
            5'd7: return $unsigned($signed(a) >>> b[4:0]);
            5'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd9: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) begin
            exp_sj[i] = 1'b0; exp_jpc[i] = '0; exp_we[i] = 1'b0; exp_rd[i] = '0; exp_wd[i] = '0;
        end
        pend_v = 1'b0; m_prev_we = 1'b0; m_halted = 1'b0; m_squash = 0; m_done_from = -1;
    endtask

    // One instruction per cycle: drive it, predict its effects, wait a cycle.
    task automatic issue(input ins_t i);
        int k;
        logic [31:0] a, b, res, wv, tsum;
        logic tk;
        logic [4:0] tg;
        read_data1 = i.rd1; read_data2 = i.rd2; rs1_idx = i.rs1; rs2_idx = i.rs2; imm = i.imm;
        in_write_reg = i.rd; in_reg_wrenable = i.we; jump_type = i.jt; mem_wrenable = i.mwe;
        mem_to_reg = i.m2r; alu_src = i.asrc; halt = i.hlt; alu_op = i.op; pc = i.pc;
        k = cyc + 1;
        if (pend_v) begin mmem[pend_a] = pend_d; pend_v = 1'b0; end
        if (m_squash > 0 || m_halted) begin
            if (m_squash > 0) m_squash--;
            m_prev_we = 1'b0;
        end else begin
            a = (m_prev_we && m_prev_rd == i.rs1 && i.rs1 != 0) ? m_prev_val : i.rd1;
            b = (m_prev_we && m_prev_rd == i.rs2 && i.rs2 != 0) ? m_prev_val : i.rd2;
            res = m_alu(i.op, a, i.asrc ? i.imm : b);
            case (i.jt)
                4'd1: tk = (a == b);
                4'd2: tk = (a != b);
                4'd3: tk = ($signed(a) < $signed(b));
                4'd4: tk = ($signed(a) >= $signed(b));
                4'd5, 4'd6: tk = 1'b1;
                default: tk = 1'b0;
            endcase
            tsum = a + i.imm;
            tg = (i.jt == 4'd6) ? tsum[4:0] : 5'((int'(i.pc) + int'(i.imm[4:0])) % 32);
            if (i.jt == 4'd5 || i.jt == 4'd6) res = 32'((int'(i.pc) + 1) % 32);
            if (i.mwe) begin pend_v = 1'b1; pend_a = res[4:0]; pend_d = b; end
            wv = i.m2r ? mmem[res[4:0]] : res;
            exp_sj[k]    = tk;
            exp_jpc[k]   = tk ? tg : 5'd0;
            exp_we[k+1]  = i.we && i.rd != 0 && !i.mwe;
            exp_rd[k+1]  = i.rd;
            exp_wd[k+1]  = wv;
            m_prev_we = exp_we[k+1]; m_prev_rd = i.rd; m_prev_val = wv;
            if (i.hlt) begin m_halted = 1'b1; m_done_from = k + 1; end
            if (tk) m_squash = FLUSH;
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (chk_en && cyc < 250) begin
            chk("should_jump", 32'(should_jump), 32'(exp_sj[cyc]));
            chk("jump_pc", 32'(jump_pc), 32'(exp_jpc[cyc]));
            chk("out_reg_wrenable", 32'(out_reg_wrenable), 32'(exp_we[cyc]));
            if (exp_we[cyc]) begin
                chk("out_write_reg", 32'(out_write_reg), 32'(exp_rd[cyc]));
                chk("write_data", write_data, exp_wd[cyc]);
            end
            chk("done", 32'(done), (m_done_from > 0 && cyc >= m_done_from) ? 32'd1 : 32'd0);
        end
    end

    function automatic ins_t nop();
        ins_t i;
        i = '{default: '0};
        return i;
    endfunction
    function automatic ins_t rr(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] s1,
                                input logic [31:0] v1, input logic [4:0] s2, input logic [31:0] v2);
        ins_t i = nop();
        i.op = op; i.rd = rd; i.we = 1'b1; i.rs1 = s1; i.rd1 = v1; i.rs2 = s2; i.rd2 = v2;
        return i;
    endfunction
    function automatic ins_t ri(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] s1,
                                input logic [31:0] v1, input logic [31:0] im);
        ins_t i = rr(op, rd, s1, v1, 5'd0, 32'd0);
        i.asrc = 1'b1; i.imm = im;
        return i;
    endfunction
    function automatic ins_t st(input logic [31:0] addr, input logic [4:0] s2, input logic [31:0] data);
        ins_t i = ri(ALU_ADD, 5'd0, 5'd22, 32'd0, addr);
        i.we = 1'b0; i.mwe = 1'b1; i.rs2 = s2; i.rd2 = data;
        return i;
    endfunction
    function automatic ins_t ld(input logic [4:0] rd, input logic [31:0] addr);
        ins_t i = ri(ALU_ADD, rd, 5'd22, 32'd0, addr);
        i.m2r = 1'b1;
        return i;
    endfunction
    function automatic ins_t br(input logic [3:0] jt, input logic [31:0] v1, input logic [31:0] v2,
                                input logic [4:0] p, input logic [31:0] im);
        ins_t i = rr(ALU_ADD, 5'd0, 5'd25, v1, 5'd26, v2);
        i.we = 1'b0; i.jt = jt; i.pc = p; i.imm = im;
        return i;
    endfunction

    logic [4:0]  tab_op [0:10];
    logic [31:0] tab_a  [0:10];
    logic [31:0] tab_b  [0:10];

    initial begin
        ins_t j;
        tab_op = '{ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, 5'd12, ALU_ADD};
        tab_a  = '{32'd10, 32'hF0F0, 32'hF0F0, 32'hF0F0, 32'd1, 32'h8000_0000, 32'h8000_0000,
                   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd77, 32'hFFFF_FFFF};
        tab_b  = '{32'd3, 32'hFF00, 32'hFF00, 32'hFF00, 32'd33, 32'd4, 32'd4, 32'd1, 32'd1, 32'd5, 32'd1};
        model_reset();
        issue_nop_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset should_jump", 32'(should_jump), 32'd0);
        chk("reset jump_pc", 32'(jump_pc), 32'd0);
        chk("reset wrenable", 32'(out_reg_wrenable), 32'd0);
        chk("reset write_data", write_data, 32'd0);
        chk("reset write_reg", 32'(out_write_reg), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Forwarding from WB with stale regfile data
        issue(rr(ALU_ADD, 5'd1, 5'd20, 32'd5, 5'd21, 32'd7));
        issue(rr(ALU_ADD, 5'd2, 5'd1, 32'd0, 5'd1, 32'd0));
        chk("fwd x1 data", write_data, 32'd12);
        chk("fwd x1 reg", 32'(out_write_reg), 32'd1);
        issue(nop());
        chk("fwd x2 data", write_data, 32'd24);

        // Store then load the same address next cycle
        issue(st(32'd3, 5'd23, 32'hDEAD_BEEF));
        issue(ld(5'd5, 32'd3));
        issue(nop());
        chk("load data", write_data, 32'hDEAD_BEEF);
        chk("load reg", 32'(out_write_reg), 32'd5);

        // Taken branch squashes the next two captures
        issue(st(32'd7, 5'd24, 32'h55));
        issue(nop());
        issue(br(JT_BEQ, 32'd3, 32'd3, 5'd4, 32'd6));
        chk("beq taken", 32'(should_jump), 32'd1);
        chk("beq target", 32'(jump_pc), 32'd10);
        issue(rr(ALU_ADD, 5'd10, 5'd20, 32'd1, 5'd21, 32'd1));
        issue(st(32'd7, 5'd24, 32'hBAD));
        chk("squashed add", 32'(out_reg_wrenable), 32'd0);
        issue(rr(ALU_ADD, 5'd12, 5'd20, 32'd1, 5'd21, 32'd2));
        issue(nop());
        chk("third retires", 32'(out_write_reg), 32'd12);
        chk("third data", write_data, 32'd3);
        issue(ld(5'd13, 32'd7));
        issue(nop());
        chk("squashed store", write_data, 32'h55);

        // JAL wraps the PC and links pc+1; x0 writes stay disabled
        j = br(JT_JAL, 32'd0, 32'd0, 5'd30, 32'd4);
        j.rd = 5'd7; j.we = 1'b1;
        issue(j);
        chk("jal target", 32'(jump_pc), 32'd2);
        issue(nop());
        chk("jal link", write_data, 32'd31);
        issue(nop());
        issue(rr(ALU_ADD, 5'd0, 5'd20, 32'd9, 5'd21, 32'd9));
        issue(nop());
        chk("x0 no write", 32'(out_reg_wrenable), 32'd0);

        // ALU coverage, then branch variants and JALR
        for (int t = 0; t < 11; t++)
            issue((t == 10) ? ri(tab_op[t], 5'(3 + t), 5'd20, tab_a[t], tab_b[t])
                            : rr(tab_op[t], 5'(3 + t), 5'd20, tab_a[t], 5'd21, tab_b[t]));
        issue(br(JT_BNE, 32'd4, 32'd4, 5'd2, 32'd3));
        issue(br(JT_BGE, 32'hFFFF_FFFB, 32'd2, 5'd2, 32'd3));
        issue(br(JT_BLT, 32'hFFFF_FFFB, 32'd2, 5'd1, 32'hFFFF_FFFE));
        chk("blt target", 32'(jump_pc), 32'd31);
        issue(nop()); issue(nop());
        j = ri(ALU_ADD, 5'd9, 5'd20, 32'd40, 32'd5);
        j.jt = JT_JALR; j.pc = 5'd9;
        issue(j);
        chk("jalr target", 32'(jump_pc), 32'd13);
        issue(nop()); issue(nop());
        issue(ld(5'd8, 32'd3));
        issue(rr(ALU_ADD, 5'd9, 5'd8, 32'd0, 5'd8, 32'd0));
        issue(nop());
        chk("load fwd", write_data, 32'hBD5B_7DDE);

        // Reset mid-stream with a store in EX
        issue(rr(ALU_ADD, 5'd17, 5'd20, 32'd1, 5'd21, 32'd1));
        issue(st(32'd3, 5'd23, 32'h1234_5678));
        #2;
        chk("pre-reset wrenable", 32'(out_reg_wrenable), 32'd1);
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("async wrenable", 32'(out_reg_wrenable), 32'd0);
        chk("async write_data", write_data, 32'd0);
        chk("async write_reg", 32'(out_write_reg), 32'd0);
        chk("async done", 32'(done), 32'd0);
        @(posedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b0;
        chk_en = 1'b1;
        issue(ld(5'd6, 32'd3));
        issue(nop());
        chk("mem kept over reset", write_data, 32'hDEAD_BEEF);

        // Halt: younger instructions are dropped, done sticks
        j = nop(); j.hlt = 1'b1;
        issue(j);
        chk("done before", 32'(done), 32'd0);
        issue(rr(ALU_ADD, 5'd14, 5'd20, 32'd1, 5'd21, 32'd1));
        chk("done rises", 32'(done), 32'd1);
        issue(rr(ALU_ADD, 5'd15, 5'd20, 32'd1, 5'd21, 32'd1));
        issue(rr(ALU_ADD, 5'd16, 5'd20, 32'd1, 5'd21, 32'd1));
        chk("halted no write", 32'(out_reg_wrenable), 32'd0);
        issue(nop()); issue(nop()); issue(nop());
        chk("done held", 32'(done), 32'd1);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic issue_nop_inputs();
        read_data1 = '0; read_data2 = '0; rs1_idx = '0; rs2_idx = '0; imm = '0;
        in_write_reg = '0; in_reg_wrenable = 1'b0; jump_type = '0; mem_wrenable = 1'b0;
        mem_to_reg = 1'b0; alu_src = 1'b0; halt = 1'b0; alu_op = '0; pc = '0;
    endtask
endmodule
